// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider (one quotient bit per cycle) for the EX stage.
// Produces {remainder, quotient} for HI/LO; supports signed/unsigned operands and annulment.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic                 signed_in,
  input  logic                 annul_in,
  input  logic [WIDTH-1:0]     src1_data_in,
  input  logic [WIDTH-1:0]     src2_data_in,
  output logic [2*WIDTH-1:0]   result_out,
  output logic                 ready_out,
  output logic                 stall_req_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t               r_state,  w_state_nxt;
  logic [CW-1:0]        r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0]     r_dvd,    w_dvd_nxt;
  logic [WIDTH-1:0]     r_dvs,    w_dvs_nxt;
  logic [WIDTH-1:0]     r_rem,    w_rem_nxt;
  logic [WIDTH-1:0]     r_quot,   w_quot_nxt;
  logic                 r_neg_q,  w_neg_q_nxt;
  logic                 r_neg_r,  w_neg_r_nxt;
  logic [2*WIDTH-1:0]   r_result, w_result_nxt;
  logic                 r_ready,  w_ready_nxt;

  logic                 w_accept;
  logic                 w_src1_neg;
  logic                 w_src2_neg;
  logic [WIDTH-1:0]     w_src1_mag;
  logic [WIDTH-1:0]     w_src2_mag;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_rem_step;
  logic [WIDTH-1:0]     w_quot_step;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_quot_fix;

  assign w_accept   = start_in & ~annul_in;
  assign w_src1_neg = signed_in & src1_data_in[WIDTH-1];
  assign w_src2_neg = signed_in & src2_data_in[WIDTH-1];
  assign w_src1_mag = w_src1_neg ? ('0 - src1_data_in) : src1_data_in;
  assign w_src2_mag = w_src2_neg ? ('0 - src2_data_in) : src2_data_in;

  // One restoring step: a borrow out of the WIDTH+1-bit trial means "keep the shifted value".
  assign w_shift     = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, r_dvs};
  assign w_rem_step  = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quot_step = {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_quot_fix  = r_neg_q ? ('0 - w_quot_step) : w_quot_step;
  assign w_rem_fix   = r_neg_r ? ('0 - w_rem_step)  : w_rem_step;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_rem_nxt    = r_rem;
    w_quot_nxt   = r_quot;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_result_nxt = r_result;
    w_ready_nxt  = 1'b0;
    unique case (r_state)
      S_FREE: begin
        if (w_accept) begin
          if (src2_data_in == '0) begin
            // Divide-by-zero reports the dividend untouched, so keep the raw operand.
            w_dvd_nxt   = src1_data_in;
            w_state_nxt = S_DIVZERO;
          end else begin
            w_dvd_nxt   = w_src1_mag;
            w_dvs_nxt   = w_src2_mag;
            w_rem_nxt   = '0;
            w_quot_nxt  = '0;
            w_cnt_nxt   = '0;
            w_neg_q_nxt = w_src1_neg ^ w_src2_neg;
            w_neg_r_nxt = w_src1_neg;
            w_state_nxt = S_ON;
          end
        end
      end
      S_DIVZERO: begin
        if (annul_in) begin
          w_state_nxt = S_FREE;
        end else begin
          w_result_nxt = {r_dvd, {WIDTH{1'b1}}};
          w_ready_nxt  = 1'b1;
          w_state_nxt  = S_END;
        end
      end
      S_ON: begin
        if (annul_in) begin
          w_state_nxt = S_FREE;
        end else begin
          w_dvd_nxt  = {r_dvd[WIDTH-2:0], 1'b0};
          w_rem_nxt  = w_rem_step;
          w_quot_nxt = w_quot_step;
          w_cnt_nxt  = r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_result_nxt = {w_rem_fix, w_quot_fix};
            w_ready_nxt  = 1'b1;
            w_state_nxt  = S_END;
          end
        end
      end
      S_END: begin
        w_state_nxt = S_FREE;
      end
      default: begin
        w_state_nxt = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_rem    <= w_rem_nxt;
      r_quot   <= w_quot_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  // Gating with start_in/annul_in/rst lets an annul or reset release the pipeline in the same cycle.
  assign stall_req_out = rst & start_in & ~annul_in &
                         ((r_state == S_FREE) | (r_state == S_DIVZERO) | (r_state == S_ON));
  assign result_out    = r_result;
  assign ready_out     = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: 32-bit and 8-bit instances checked against an arithmetic reference.
module tb_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st32, sg32, an32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        rdy32, stl32;
  logic        st8, sg8, an8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8, stl8;

  div_unit #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst), .start_in(st32), .signed_in(sg32), .annul_in(an32),
    .src1_data_in(a32), .src2_data_in(b32),
    .result_out(res32), .ready_out(rdy32), .stall_req_out(stl32));

  div_unit #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start_in(st8), .signed_in(sg8), .annul_in(an8),
    .src1_data_in(a8), .src2_data_in(b8),
    .result_out(res8), .ready_out(rdy8), .stall_req_out(stl8));

  typedef struct {
    longint unsigned res;
    int              cyc;
  } exp_t;

  exp_t            q32[$];
  exp_t            q8[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  longint unsigned last32 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain integer division; C-style truncation gives the remainder the dividend's sign.
  function automatic longint unsigned ref_div(input longint unsigned a, input longint unsigned b,
                                              input bit sgn, input int w);
    longint unsigned mask;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 1;
    if (b == 0) return (a << w) | mask;
    if (sgn) begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(a / b);
      r = longint'(a % b);
    end
    return ((longint'(r) & mask) << w) | (longint'(q) & mask);
  endfunction

  always @(negedge clk) begin
    if (rdy32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL ready32_unexpected: ready_out=1 at cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("res32", res32, e.res);
        chk("ready32_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
    if (rdy8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL ready8_unexpected: ready_out=1 at cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("res8", res8, e.res);
        chk("ready8_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the divide (or its annul).
  task automatic div32(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int annul_k);
    int   c0, lat;
    exp_t e;
    bit   annulled;
    lat = (b == 0) ? 2 : 33;
    c0 = cyc;
    annulled = 0;
    st32 = 1'b1; sg32 = sgn; a32 = a; b32 = b; an32 = 1'b0;
    if (annul_k < 0) begin
      e.res = ref_div(a, b, sgn, 32);
      e.cyc = c0 + lat;
      q32.push_back(e);
    end
    for (int i = 0; i < lat && !annulled; i++) begin
      if (i == annul_k) an32 = 1'b1;
      @(negedge clk);
      chk("stall32", stl32, (i == annul_k) ? 0 : 1);
      if (i == annul_k) annulled = 1;
      @(posedge clk); #1;
    end
    if (annulled) begin
      st32 = 1'b0; an32 = 1'b0;
      chk("res32_held_after_annul", res32, last32);
    end else begin
      @(negedge clk);
      chk("stall32_ready_cycle", stl32, 0);
      last32 = ref_div(a, b, sgn, 32);
      @(posedge clk); #1;
      st32 = 1'b0;
    end
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    int   c0, lat;
    exp_t e;
    lat = (b == 0) ? 2 : 9;
    c0 = cyc;
    st8 = 1'b1; sg8 = sgn; a8 = a; b8 = b; an8 = 1'b0;
    e.res = ref_div(a, b, sgn, 8);
    e.cyc = c0 + lat;
    q8.push_back(e);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("stall8", stl8, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall8_ready_cycle", stl8, 0);
    @(posedge clk); #1;
    st8 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int          lat, ak;
    rst = 1'b0;
    st32 = 0; sg32 = 0; an32 = 0; a32 = '0; b32 = '0;
    st8 = 0;  sg8 = 0;  an8 = 0;  a8 = '0;  b8 = '0;
    @(negedge clk);
    chk("reset_res32", res32, 0);
    chk("reset_ready32", rdy32, 0);
    chk("reset_stall32", stl32, 0);
    chk("reset_res8", res8, 0);
    chk("reset_ready8", rdy8, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    div32(32'd100, 32'd7, 1'b0, -1);
    chk("ref_100_7", ref_div(100, 7, 0, 32), 64'h00000002_0000000E);
    div32(32'hFFFFFFF9, 32'h2, 1'b1, -1);
    div32(32'h80000000, 32'hFFFFFFFF, 1'b1, -1);
    div32(32'd5, 32'd0, 1'b0, -1);
    div32(32'd5, 32'd0, 1'b1, -1);
    div32(32'd100, 32'd7, 1'b0, 10);
    div32(32'd9, 32'd3, 1'b0, -1);
    div32(32'd77, 32'd0, 1'b0, 1);
    div32(32'd12, 32'd5, 1'b0, 0);

    // Asynchronous reset in the middle of a divide
    st32 = 1'b1; sg32 = 1'b0; a32 = 32'd1000; b32 = 32'd3;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_res32", res32, 0);
    chk("midreset_ready32", rdy32, 0);
    chk("midreset_stall32", stl32, 0);
    st32 = 1'b0;
    last32 = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    div32(32'd100, 32'd7, 1'b0, -1);

    div8(8'd200, 8'd9, 1'b0);
    div8(8'd37, 8'd5, 1'b0);
    div8(8'h80, 8'hFF, 1'b1);
    div8(8'hF3, 8'd0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = 32'hFFFFFFFF;
        2:       begin ra = 32'h80000000; rb = $urandom; end
        3:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      lat = (rb == 0) ? 2 : 33;
      ak  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      div32(ra, rb, 1'($urandom_range(0, 1)), ak);
    end

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      div8(ra[7:0], rb[7:0], 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q32_drained", q32.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider for the execute stage, producing quotient and remainder for the HI/LO path in one bit per cycle (restoring algorithm). It accepts signed or unsigned operands and raises a stall request to hold the pipeline while busy. The EX stage can cancel an in-flight divide when its instruction is flushed. It replaces single-cycle ALU division so that WIDTH can scale without lengthening the critical path.

## Interface
- WIDTH, 32: operand width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start_in  in  1  request a divide; sampled only in FREE.
- signed_in  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start_in.
- annul_in  in  1  cancel the in-flight divide; also blocks acceptance.
- src1_data_in  in  WIDTH  dividend; sampled with start_in.
- src2_data_in  in  WIDTH  divisor; sampled with start_in.
- result_out  out  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO. Registered.
- ready_out  out  1  result_out valid; registered, high for exactly one cycle per completed divide.
- stall_req_out  out  1  combinational pipeline stall request.

## Operation
- States: FREE, DIVZERO, ON, END. Reset state is FREE.
- Reset values: result_out = 0, ready_out = 0, internal counter = 0. stall_req_out = 0 whenever start_in = 0.
- Transitions out of FREE (only when start_in=1 and annul_in=0):
  - Divisor = 0: go to DIVZERO.
  - Otherwise: latch operand magnitudes, signed_in, and the operand signs; clear the counter; go to ON.
- In FREE, a start_in with annul_in=1 is ignored.
- DIVZERO: go to END on the next edge with quotient = all ones and remainder = the dividend as presented (no sign processing).
- ON, each edge:
  - Shift the partial remainder left, bringing in the next dividend bit (MSB first).
  - Trial-subtract the divisor magnitude in WIDTH+1 bits. If non-negative, keep the difference and shift a quotient bit of 1; otherwise shift in 0.
  - Counter increments. After WIDTH steps, go to END.
- Signed fix-up on entry to END:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Most-negative / −1 yields quotient = most-negative and remainder 0, with no trap.
- END: result_out is loaded and ready_out=1 for this one cycle; next edge goes unconditionally to FREE.
- annul_in=1 in DIVZERO or ON: go to FREE on the next edge. ready_out is never asserted for that divide and result_out keeps its previous value.
- annul_in=1 in END: no effect, since ready_out is already high and the consumer discards the result.
- result_out holds the last completed result until the next completion.
- stall_req_out = (FREE & start_in & !annul_in) | DIVZERO | ON. It is 0 in END.

## Timing
- Cycle numbering: start_in accepted in cycle 0 (edge at end of cycle 0).
- Non-zero divisor: ON for cycles 1..WIDTH; ready_out high in cycle WIDTH+1 (33 for WIDTH=32).
- Zero divisor: DIVZERO in cycle 1; ready_out high in cycle 2.
- stall_req_out is high from cycle 0 through the cycle before ready_out, then low in the ready_out cycle. EX holds start_in and its operands stable for that whole window.
- Back-to-back divides: a start_in arriving in the cycle after END (FREE) is accepted there. This gives a minimum issue interval of WIDTH+2 cycles.
- Annul in cycle k (state ON or DIVZERO): stall_req_out drops in cycle k, since annul masks acceptance and the state goes to FREE at edge k. A new start is accepted from cycle k+1.
- Reset asserted mid-operation: state goes to FREE and all outputs clear immediately, without waiting for a clock edge. The first accept is possible on the first edge after rst deasserts.

## Test plan
- WIDTH=32, unsigned 100/7, start in cycle 0 -> ready_out high only in cycle 33, result_out = {0x00000002, 0x0000000E}; stall_req_out high in cycles 0–32.
- Signed −7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- 5/0 (signed or unsigned) -> ready_out in cycle 2, result_out = {0x00000005, 0xFFFFFFFF}; stall_req_out low from cycle 2.
- Start 100/7, annul_in pulsed in cycle 10 -> stall_req_out low in cycle 10, no ready_out ever, result_out unchanged. New start 9/3 in cycle 11 -> ready_out in cycle 44, quotient 3, remainder 0.
- Start a divide, assert rst low in cycle 15 -> result_out = 0, ready_out = 0, stall_req_out = 0 immediately. After release, 100/7 completes normally.
- WIDTH=8 instance, unsigned 200/9 -> ready_out in cycle 9, result_out = {0x02, 0x16}. Two back-to-back divides -> second accepted in cycle 10.
